// File: rtl/patgen_pkg.sv
// Shared definitions for the video test-pattern source: mode encoding,
// 8-bit reference palettes and component-width scaling.
package patgen_pkg;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_RAMP  = 2'd3;

    // Solid colours cycled once per frame: turquoise, carrot, sunflower, pomegranate
    localparam logic [23:0] SOLID_PAL [4] = '{
        24'h1ABC9C, 24'hE67E22, 24'hF1C40F, 24'hC0392B
    };

    // Bar colours left to right; any non-zero component means full scale
    localparam logic [23:0] BAR_PAL [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Map an 8-bit component onto comp_w bits; caller keeps the low comp_w bits
    function automatic logic [31:0] scale_comp8(input logic [7:0] c, input int comp_w);
        if (comp_w >= 8) begin
            return 32'(c) << (comp_w - 8);
        end
        return 32'(c) >> (8 - comp_w);
    endfunction

endpackage

// File: rtl/patgen_raster_counter.sv
// Raster position counter: walks x across each line and y down the frame,
// advancing one pixel per accepted beat.
module patgen_raster_counter
    import patgen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          advance,
    output logic [cnt_w(H_ACTIVE)-1:0]    x,
    output logic [cnt_w(V_ACTIVE)-1:0]    y,
    output logic                          eol,
    output logic                          eof
);

    localparam int XW = cnt_w(H_ACTIVE);
    localparam int YW = cnt_w(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    assign eol = (x == X_LAST);
    assign eof = eol && (y == Y_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= eof ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Video test-pattern source (solid cycle, colour bars, checker, grey ramp) on a
// valid/ready stream. Define PATGEN_SCROLL_EN to scroll bars/checker left one pixel per frame.
module video_pattern_gen
    import patgen_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COMP_W     = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [1:0]            Mode,
    input  logic                  VideoReady,
    output logic                  VideoValid,
    output logic [3*COMP_W-1:0]   Video,
    output logic                  Sof,
    output logic                  Eol
);

    localparam int XW    = cnt_w(H_ACTIVE);
    localparam int YW    = cnt_w(V_ACTIVE);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [COMP_W-1:0] FS = '1;

    // Checker bits beyond the counter width are constant zero
    localparam bit CX_OK  = (CHECK_LOG2 < XW);
    localparam bit CY_OK  = (CHECK_LOG2 < YW);
    localparam int CX_IDX = CX_OK ? CHECK_LOG2 : 0;
    localparam int CY_IDX = CY_OK ? CHECK_LOG2 : 0;

    if ((H_ACTIVE % 8) != 0 || H_ACTIVE < 8) begin : g_bad_h
        $error("H_ACTIVE must be a multiple of 8 and at least 8");
    end
    if (V_ACTIVE < 1) begin : g_bad_v
        $error("V_ACTIVE must be at least 1");
    end

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          eol;
    logic          eof;
    logic          vld;
    logic          advance;
    logic [1:0]    mode_q;
    logic [1:0]    sidx;

    assign advance = vld && VideoReady;

    patgen_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_raster (
        .Clock   (Clock),
        .Reset   (Reset),
        .advance (advance),
        .x       (x),
        .y       (y),
        .eol     (eol),
        .eof     (eof)
    );

    // Mode and solid colour only change between frames so a frame is never mixed
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vld    <= 1'b0;
            mode_q <= Mode;
            sidx   <= '0;
        end else begin
            vld <= 1'b1;
            if (advance && eof) begin
                mode_q <= Mode;
                sidx   <= sidx + 2'd1;
            end
        end
    end

`ifdef PATGEN_SCROLL_EN
    localparam int XW1 = XW + 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW:0]   H_FULL = XW1'(H_ACTIVE);

    logic [XW-1:0] scroll;
    logic [XW:0]   xs_sum;
    logic [XW-1:0] xs;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            scroll <= '0;
        end else if (advance && eof) begin
            scroll <= (scroll == X_LAST) ? '0 : scroll + 1'b1;
        end
    end

    // Both operands are below H_ACTIVE, so one conditional subtract wraps the sum
    always_comb begin
        xs_sum = {1'b0, x} + {1'b0, scroll};
        if (xs_sum >= H_FULL) begin
            xs = XW'(xs_sum - H_FULL);
        end else begin
            xs = xs_sum[XW-1:0];
        end
    end
`else
    logic [XW-1:0] xs;
    assign xs = x;
`endif

    function automatic logic [COMP_W-1:0] comp_scale(input logic [7:0] c);
        return COMP_W'(scale_comp8(c, COMP_W));
    endfunction

    function automatic logic [COMP_W-1:0] comp_full(input logic [7:0] c);
        return (c != 8'd0) ? FS : '0;
    endfunction

    logic [2:0]        bar;
    logic              chk;
    logic [23:0]       pal;
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;

    always_comb begin
        bar = 3'(xs / XW'(BAR_W));
        chk = (CX_OK && xs[CX_IDX]) ^ (CY_OK && y[CY_IDX]);
        pal = '0;
        r   = '0;
        g   = '0;
        b   = '0;
        case (mode_q)
            MODE_SOLID: begin
                pal = SOLID_PAL[sidx];
                r   = comp_scale(pal[23:16]);
                g   = comp_scale(pal[15:8]);
                b   = comp_scale(pal[7:0]);
            end
            MODE_BARS: begin
                pal = BAR_PAL[bar];
                r   = comp_full(pal[23:16]);
                g   = comp_full(pal[15:8]);
                b   = comp_full(pal[7:0]);
            end
            MODE_CHECK: begin
                if (chk) begin
                    r = FS;
                    g = FS;
                    b = FS;
                end
            end
            default: begin
                r = COMP_W'(x);
                g = COMP_W'(x);
                b = COMP_W'(x);
            end
        endcase
    end

    assign VideoValid = vld;
    assign Video      = {r, g, b};
    assign Sof        = vld && (x == '0) && (y == '0);
    assign Eol        = vld && eol;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: a frame-level reference model queues
// expected beats, a monitor compares them as the DUT presents each beat.
module tb_video_pattern_gen;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int CW    = 8;
    localparam int CL    = 1;
    localparam int FRAME = H * V;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic [1:0]     Mode = 2'd0;
    logic           VideoReady = 1'b1;
    logic           VideoValid;
    logic [3*CW-1:0] Video;
    logic           Sof;
    logic           Eol;

    video_pattern_gen #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .COMP_W     (CW),
        .CHECK_LOG2 (CL)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Mode       (Mode),
        .VideoReady (VideoReady),
        .VideoValid (VideoValid),
        .Video      (Video),
        .Sof        (Sof),
        .Eol        (Eol)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [23:0] pix;
        logic        sof;
        logic        eol;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_beats  = 0;

    logic  m_valid = 1'b0;
    int    m_frame = 0;
    int    m_n     = 0;
    int    m_mode  = 0;

    function automatic logic [23:0] ref_pixel(int mode, int frame, int n);
        int x;
        int y;
        int xe;
        x  = n % H;
        y  = n / H;
        xe = x;
`ifdef PATGEN_SCROLL_EN
        if (mode == 1 || mode == 2) xe = (x + frame) % H;
`endif
        if (mode == 0) begin
            case (frame % 4)
                0: return 24'h1ABC9C;
                1: return 24'hE67E22;
                2: return 24'hF1C40F;
                default: return 24'hC0392B;
            endcase
        end
        if (mode == 1) begin
            case ((xe * 8) / H)
                0: return 24'hFFFFFF;
                1: return 24'hFFFF00;
                2: return 24'h00FFFF;
                3: return 24'h00FF00;
                4: return 24'hFF00FF;
                5: return 24'hFF0000;
                6: return 24'h0000FF;
                default: return 24'h000000;
            endcase
        end
        if (mode == 2) begin
            return ((((xe >> CL) & 1) ^ ((y >> CL) & 1)) != 0) ? 24'hFFFFFF : 24'h000000;
        end
        return {3{8'(xe % 256)}};
    endfunction

    function automatic beat_t ref_beat(int mode, int frame, int n);
        beat_t bt;
        bt.pix = ref_pixel(mode, frame, n);
        bt.sof = (n == 0);
        bt.eol = ((n % H) == H - 1);
        return bt;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: tracks frame/beat from the stimulus it sees at each edge
    initial begin
        forever begin
            @(posedge Clock);
            if (Reset) begin
                m_valid = 1'b0;
                m_frame = 0;
                m_n     = 0;
                m_mode  = int'(Mode);
                exp_q.delete();
            end else begin
                if (m_valid && VideoReady) begin
                    if (m_n == FRAME - 1) begin
                        m_n = 0;
                        m_frame++;
                        m_mode = int'(Mode);
                    end else begin
                        m_n++;
                    end
                    exp_q.push_back(ref_beat(m_mode, m_frame, m_n));
                end else if (!m_valid) begin
                    exp_q.push_back(ref_beat(m_mode, m_frame, m_n));
                end
                m_valid = 1'b1;
            end
        end
    end

    // Monitor: compares the presented beat every cycle, retires it on acceptance
    initial begin
        beat_t done;
        forever begin
            @(negedge Clock);
            check("valid", 32'(VideoValid), 32'(m_valid));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got beat with no expectation at %0t", $time);
                end else begin
                    check("video", 32'(Video), 32'(exp_q[0].pix));
                    check("sof", 32'(Sof), 32'(exp_q[0].sof));
                    check("eol", 32'(Eol), 32'(exp_q[0].eol));
                    if (VideoReady) begin
                        done = exp_q.pop_front();
                        n_beats++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    initial begin
        Reset = 1'b1;
        Mode = 2'd0;
        VideoReady = 1'b1;
        repeat (3) step();
        Reset = 1'b0;

        // Solid mode with continuous acceptance across more than four frames
        repeat (300) step();

        // Random back-pressure and mid-frame mode changes
        for (int i = 0; i < 1500; i++) begin
            step();
            VideoReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) Mode = 2'($urandom_range(0, 3));
        end

        // Mid-frame resets with a fresh mode sampled during reset
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(20, 150)) begin
                step();
                VideoReady = ($urandom_range(0, 2) != 0);
            end
            Reset = 1'b1;
            Mode = 2'($urandom_range(0, 3));
            repeat (2) step();
            Reset = 1'b0;
        end

        // Each mode held for several whole frames
        VideoReady = 1'b1;
        for (int m = 0; m < 4; m++) begin
            Mode = 2'(m);
            repeat (3 * FRAME) step();
        end

        check("beats_seen", 32'(n_beats >= 1000), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
